ex_mem_reg: RTL

EX_MEM_REG -- requirements
Module: ex_mem_reg

---
 rtl/ex_mem_reg.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/ex_mem_reg.sv
// rtl/ex_mem_reg.sv - EX/MEM pipeline register with flush/stall and optional overflow trap
// Optional feature: define EXMEM_OVF_TRAP_EN to compile in the overflow trap (exc_ovf/epc).
module ex_mem_reg #(
  parameter int XLEN  = 32,
  parameter int RADDR = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             flush,
  input  logic             ex_valid,
  input  logic [XLEN-1:0]  ex_alu_result,
  input  logic [XLEN-1:0]  ex_wdata,
  input  logic [RADDR-1:0] ex_dst_reg,
  input  logic [XLEN-1:0]  ex_pc,
  input  logic             ex_reg_write,
  input  logic             ex_mem_read,
  input  logic             ex_mem_write,
  input  logic             ex_mem_to_reg,
  input  logic             ex_overflow,
  output logic             mem_valid,
  output logic [XLEN-1:0]  mem_alu_result,
  output logic [XLEN-1:0]  mem_wdata,
  output logic [XLEN-1:0]  mem_pc,
  output logic [RADDR-1:0] mem_dst_reg,
  output logic             mem_reg_write,
  output logic             mem_mem_read,
  output logic             mem_mem_write,
  output logic             mem_mem_to_reg,
  output logic             exc_ovf,
  output logic [XLEN-1:0]  epc
);

  logic             valid_q, valid_d;
  logic [XLEN-1:0]  alu_q, alu_d;
  logic [XLEN-1:0]  wdata_q, wdata_d;
  logic [XLEN-1:0]  pc_q, pc_d;
  logic [RADDR-1:0] dst_q, dst_d;
  logic             rw_q, rw_d;
  logic             mr_q, mr_d;
  logic             mw_q, mw_d;
  logic             m2r_q, m2r_d;

  logic trap;
  logic load_bubble;
  logic load_capture;
  logic take_trap;

`ifdef EXMEM_OVF_TRAP_EN
  logic             exc_q, exc_d;
  logic [XLEN-1:0]  epc_q, epc_d;

  assign trap = ex_valid & ex_overflow & ex_reg_write;
`else
  logic unused_ovf;

  assign unused_ovf = ex_overflow;
  assign trap       = 1'b0;
`endif

  // Only a capture edge may trap; flush and stall both mask it.
  assign take_trap    = ~flush & ~stall & trap;
  assign load_bubble  = flush | (~stall & (~ex_valid | trap));
  assign load_capture = ~flush & ~stall & ex_valid & ~trap;

  always_comb begin
    valid_d = valid_q;
    alu_d   = alu_q;
    wdata_d = wdata_q;
    pc_d    = pc_q;
    dst_d   = dst_q;
    rw_d    = rw_q;
    mr_d    = mr_q;
    mw_d    = mw_q;
    m2r_d   = m2r_q;
    if (load_bubble) begin
      valid_d = 1'b0;
      alu_d   = '0;
      wdata_d = '0;
      pc_d    = '0;
      dst_d   = '0;
      rw_d    = 1'b0;
      mr_d    = 1'b0;
      mw_d    = 1'b0;
      m2r_d   = 1'b0;
    end else if (load_capture) begin
      valid_d = 1'b1;
      alu_d   = ex_alu_result;
      wdata_d = ex_wdata;
      pc_d    = ex_pc;
      dst_d   = ex_dst_reg;
      // Writes to $zero are dropped here so later stages never see them.
      rw_d    = ex_reg_write & (ex_dst_reg != '0);
      mr_d    = ex_mem_read;
      mw_d    = ex_mem_write;
      m2r_d   = ex_mem_to_reg;
    end
  end

`ifdef EXMEM_OVF_TRAP_EN
  always_comb begin
    exc_d = take_trap;
    epc_d = take_trap ? ex_pc : epc_q;
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      alu_q   <= '0;
      wdata_q <= '0;
      pc_q    <= '0;
      dst_q   <= '0;
      rw_q    <= 1'b0;
      mr_q    <= 1'b0;
      mw_q    <= 1'b0;
      m2r_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      alu_q   <= alu_d;
      wdata_q <= wdata_d;
      pc_q    <= pc_d;
      dst_q   <= dst_d;
      rw_q    <= rw_d;
      mr_q    <= mr_d;
      mw_q    <= mw_d;
      m2r_q   <= m2r_d;
    end
  end

`ifdef EXMEM_OVF_TRAP_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      exc_q <= 1'b0;
      epc_q <= '0;
    end else begin
      exc_q <= exc_d;
      epc_q <= epc_d;
    end
  end

  assign exc_ovf = exc_q;
  assign epc     = epc_q;
`else
  assign exc_ovf = 1'b0;
  assign epc     = '0;
`endif

  assign mem_valid      = valid_q;
  assign mem_alu_result = alu_q;
  assign mem_wdata      = wdata_q;
  assign mem_pc         = pc_q;
  assign mem_dst_reg    = dst_q;
  assign mem_reg_write  = rw_q;
  assign mem_mem_read   = mr_q;
  assign mem_mem_write  = mw_q;
  assign mem_mem_to_reg = m2r_q;

endmodule
